repairclk_module: RTL and testbench
===================================

REPAIRCLK_MODULE -- requirements
Module: repairclk_module

Interface
REQ-001 SHALL have parameter SB_MSG_WIDTH, default 4, sideband message code width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 8000, maximum cycles spent in any WAIT_* state.
REQ-003 SHALL have port CLK  in  1  single block clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_MBINIT_CAL_end  in  1  enable; level from the calibration stage.
REQ-006 SHALL have port i_Busy_SideBand  in  1  sideband transmitter busy.
REQ-007 SHALL have port i_falling_edge_busy  in  1  one-cycle pulse on busy 1->0.
REQ-008 SHALL have port i_RX_SbMessage  in  SB_MSG_WIDTH  received message code.
REQ-009 SHALL have port i_msg_valid  in  1  i_RX_SbMessage qualifier.
REQ-010 SHALL have port i_RX_data  in  3  result payload {RTRK,RCKN,RCKP}; valid with i_msg_valid.
REQ-011 SHALL have port i_clk_pattern_done  in  1  pulse from pattern generator on completion.
REQ-012 SHALL have port o_TX_SbMessage  out  SB_MSG_WIDTH  message code to send.
REQ-013 SHALL have port o_ValidOutDatat_Module  out  1  o_TX_SbMessage qualifier.
REQ-014 SHALL have port o_clk_pattern_en  out  1  request clock-repair pattern transmission.
REQ-015 SHALL have port o_MBINIT_REPAIRCLK_end  out  1  stage passed; held while enabled.
REQ-016 SHALL have port o_REPAIRCLK_error  out  1  stage failed; held while enabled.

Function
REQ-017 Message codes SHALL be: INIT_req 0001, INIT_resp 0010, RESULT_req 0011, RESULT_resp 0100, DONE_req 0101, DONE_resp 0110.
REQ-018 States SHALL be: IDLE, SEND_INIT, WAIT_INIT, PATTERN, SEND_RESULT, WAIT_RESULT, SEND_DONE, WAIT_DONE, DONE, ERROR.
REQ-019 IDLE->SEND_INIT SHALL occur when i_MBINIT_CAL_end=1 and i_Busy_SideBand=0.
REQ-020 Each SEND_* state SHALL advance to its WAIT_* state when i_falling_edge_busy=1 and i_Busy_SideBand=0; otherwise it holds.
REQ-021 In SEND_* states, o_ValidOutDatat_Module=1 and o_TX_SbMessage=the matching req code; in all other states both are 0.
REQ-022 WAIT_INIT->PATTERN SHALL occur on i_msg_valid with INIT_resp.
REQ-023 PATTERN SHALL drive o_clk_pattern_en=1 and advance to SEND_RESULT on i_clk_pattern_done.
REQ-024 WAIT_RESULT SHALL capture i_RX_data on i_msg_valid with RESULT_resp; 3'b111 -> SEND_DONE, any other value -> ERROR.
REQ-025 WAIT_DONE->DONE SHALL occur on i_msg_valid with DONE_resp.
REQ-026 In WAIT_* states, valid messages with a non-matching code SHALL be ignored.
REQ-027 A 16-bit counter SHALL clear on entry to each WAIT_* state and increment each cycle in it; reaching TIMEOUT_CYCLES-1 without the expected response -> ERROR.
REQ-028 If the matching response and the timeout occur in the same cycle, the response SHALL win.
REQ-029 i_MBINIT_CAL_end=0 in any state SHALL force IDLE on the next edge, overriding every other transition.
REQ-030 DONE and ERROR SHALL hold until i_MBINIT_CAL_end falls.
REQ-031 All outputs SHALL be registered and decoded from the next state, so they reflect a new state in the same cycle the state register updates.
REQ-032 o_MBINIT_REPAIRCLK_end=1 only in DONE and o_REPAIRCLK_error=1 only in ERROR; never both.

Reset
REQ-033 On rst=1 at a CLK edge, the state SHALL be IDLE, the counter 0, the captured result 0, and every output 0.
REQ-034 Reset SHALL abort any handshake in progress and drop o_clk_pattern_en in the same edge.

Structure
REQ-035 Message codes and the state encoding SHALL reside in the shared MBINIT package used by all MBINIT stages.
REQ-036 The timeout counter SHALL be a sub-module, mbinit_timeout_counter (inputs clear and enable; output expired), reusable by sibling stages.

Verification
REQ-037 Happy path: enable; busy pulse; INIT_resp; pattern_done; RESULT_resp with data 111; DONE_resp -> messages 0001, 0011, 0101 in order; o_MBINIT_REPAIRCLK_end=1.
REQ-038 Failed result: RESULT_resp with i_RX_data=3'b101 -> ERROR; o_REPAIRCLK_error=1; no 0101 sent.
REQ-039 Timeout: no INIT_resp for TIMEOUT_CYCLES=16 -> o_REPAIRCLK_error=1 on the 16th WAIT_INIT cycle.
REQ-040 Race: DONE_resp in the same cycle as timeout expiry -> DONE, error stays 0.
REQ-041 Abort: drop i_MBINIT_CAL_end during PATTERN -> next cycle IDLE, o_clk_pattern_en=0, all outputs 0.
REQ-042 Stray message: DONE_resp arriving in WAIT_INIT -> ignored; state stays WAIT_INIT.

Source files
------------

// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: sideband message codes and the REPAIRCLK state encoding.
package mbinit_pkg;

  localparam logic [3:0] MSG_INIT_REQ    = 4'b0001;
  localparam logic [3:0] MSG_INIT_RESP   = 4'b0010;
  localparam logic [3:0] MSG_RESULT_REQ  = 4'b0011;
  localparam logic [3:0] MSG_RESULT_RESP = 4'b0100;
  localparam logic [3:0] MSG_DONE_REQ    = 4'b0101;
  localparam logic [3:0] MSG_DONE_RESP   = 4'b0110;

  typedef enum logic [3:0] {
    IDLE,
    SEND_INIT,
    WAIT_INIT,
    PATTERN,
    SEND_RESULT,
    WAIT_RESULT,
    SEND_DONE,
    WAIT_DONE,
    DONE,
    ERROR
  } repairclk_state_e;

  function automatic logic is_wait_state(repairclk_state_e s);
    return (s == WAIT_INIT) || (s == WAIT_RESULT) || (s == WAIT_DONE);
  endfunction

endpackage

// File: rtl/mbinit_timeout_counter.sv
// Response timeout for MBINIT wait states; expired is raised on the last permitted cycle.
module mbinit_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic CLK,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  // Count freezes at the limit so a late exit from the wait state cannot wrap it.
  always_ff @(posedge CLK) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 16'd1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/repairclk_module.sv
// MBINIT REPAIRCLK stage: INIT/RESULT/DONE sideband handshake around a clock-repair pattern.
module repairclk_module
  import mbinit_pkg::*;
#(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    i_MBINIT_CAL_end,
  input  logic                    i_Busy_SideBand,
  input  logic                    i_falling_edge_busy,
  input  logic [SB_MSG_WIDTH-1:0] i_RX_SbMessage,
  input  logic                    i_msg_valid,
  input  logic [2:0]              i_RX_data,
  input  logic                    i_clk_pattern_done,
  output logic [SB_MSG_WIDTH-1:0] o_TX_SbMessage,
  output logic                    o_ValidOutDatat_Module,
  output logic                    o_clk_pattern_en,
  output logic                    o_MBINIT_REPAIRCLK_end,
  output logic                    o_REPAIRCLK_error
);

  repairclk_state_e state, next_state;
  logic [2:0] result_q;
  logic timeout_expired;
  logic in_wait;
  logic send_done;
  logic hit_init, hit_result, hit_done;

  logic [SB_MSG_WIDTH-1:0] tx_msg_d;
  logic tx_valid_d, pattern_en_d, stage_end_d, stage_error_d;

  assign in_wait    = is_wait_state(state);
  assign send_done  = i_falling_edge_busy && !i_Busy_SideBand;
  assign hit_init   = i_msg_valid && (i_RX_SbMessage == SB_MSG_WIDTH'(MSG_INIT_RESP));
  assign hit_result = i_msg_valid && (i_RX_SbMessage == SB_MSG_WIDTH'(MSG_RESULT_RESP));
  assign hit_done   = i_msg_valid && (i_RX_SbMessage == SB_MSG_WIDTH'(MSG_DONE_RESP));

  mbinit_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK    (CLK),
    .rst    (rst),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(timeout_expired)
  );

  // Outputs are registered from next_state so they change on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state                  <= IDLE;
      result_q               <= '0;
      o_TX_SbMessage         <= '0;
      o_ValidOutDatat_Module <= 1'b0;
      o_clk_pattern_en       <= 1'b0;
      o_MBINIT_REPAIRCLK_end <= 1'b0;
      o_REPAIRCLK_error      <= 1'b0;
    end else begin
      state                  <= next_state;
      o_TX_SbMessage         <= tx_msg_d;
      o_ValidOutDatat_Module <= tx_valid_d;
      o_clk_pattern_en       <= pattern_en_d;
      o_MBINIT_REPAIRCLK_end <= stage_end_d;
      o_REPAIRCLK_error      <= stage_error_d;
      if (state == WAIT_RESULT && hit_result) begin
        result_q <= i_RX_data;
      end
    end
  end

  // A matching response is tested before the timeout so it wins a same-cycle race.
  always_comb begin
    next_state = state;
    if (!i_MBINIT_CAL_end) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:        if (!i_Busy_SideBand) next_state = SEND_INIT;
        SEND_INIT:   if (send_done) next_state = WAIT_INIT;
        WAIT_INIT: begin
          if (hit_init)             next_state = PATTERN;
          else if (timeout_expired) next_state = ERROR;
        end
        PATTERN:     if (i_clk_pattern_done) next_state = SEND_RESULT;
        SEND_RESULT: if (send_done) next_state = WAIT_RESULT;
        WAIT_RESULT: begin
          if (hit_result)           next_state = (i_RX_data == 3'b111) ? SEND_DONE : ERROR;
          else if (timeout_expired) next_state = ERROR;
        end
        SEND_DONE:   if (send_done) next_state = WAIT_DONE;
        WAIT_DONE: begin
          if (hit_done)             next_state = DONE;
          else if (timeout_expired) next_state = ERROR;
        end
        DONE:        next_state = DONE;
        ERROR:       next_state = ERROR;
        default:     next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    tx_msg_d      = '0;
    tx_valid_d    = 1'b0;
    pattern_en_d  = 1'b0;
    stage_end_d   = 1'b0;
    stage_error_d = 1'b0;
    case (next_state)
      SEND_INIT: begin
        tx_msg_d   = SB_MSG_WIDTH'(MSG_INIT_REQ);
        tx_valid_d = 1'b1;
      end
      SEND_RESULT: begin
        tx_msg_d   = SB_MSG_WIDTH'(MSG_RESULT_REQ);
        tx_valid_d = 1'b1;
      end
      SEND_DONE: begin
        tx_msg_d   = SB_MSG_WIDTH'(MSG_DONE_REQ);
        tx_valid_d = 1'b1;
      end
      PATTERN: pattern_en_d  = 1'b1;
      DONE:    stage_end_d   = 1'b1;
      ERROR:   stage_error_d = 1'b1;
      default: ;
    endcase
  end

  // SEND_DONE is only reachable from WAIT_RESULT through a clean captured result.
  assert property (@(posedge CLK) disable iff (rst)
    (state == SEND_DONE && $past(state) == WAIT_RESULT) |-> (result_q == 3'b111));

endmodule

// File: tb/tb_repairclk_module.sv
// Directed table-driven bench for repairclk_module with hand-written multi-cycle corner cases.
module tb_repairclk_module;

  localparam int W = 4;

  // Expected output bundle {tx_msg[3:0], valid, pattern_en, stage_end, stage_error}
  localparam logic [7:0] E_IDLE  = 8'h00;
  localparam logic [7:0] E_SINIT = 8'h18;
  localparam logic [7:0] E_SRES  = 8'h38;
  localparam logic [7:0] E_SDONE = 8'h58;
  localparam logic [7:0] E_PAT   = 8'h04;
  localparam logic [7:0] E_DONE  = 8'h02;
  localparam logic [7:0] E_ERR   = 8'h01;

  localparam logic [3:0] INIT_RESP   = 4'd2;
  localparam logic [3:0] RESULT_RESP = 4'd4;
  localparam logic [3:0] DONE_RESP   = 4'd6;

  typedef struct {
    logic       rst;
    logic       cal;
    logic       busy;
    logic       fe;
    logic       vld;
    logic [3:0] msg;
    logic [2:0] data;
    logic       pdone;
    logic [7:0] expOut;
  } vec_t;

  logic CLK = 1'b0;
  logic rst, cal, busy, fe, vld, pdone;
  logic [W-1:0] msg;
  logic [2:0] data;
  logic [W-1:0] txMsg;
  logic txValid, patternEn, stageEnd, stageError;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 CLK = ~CLK;

  repairclk_module #(
    .SB_MSG_WIDTH  (W),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK                   (CLK),
    .rst                   (rst),
    .i_MBINIT_CAL_end      (cal),
    .i_Busy_SideBand       (busy),
    .i_falling_edge_busy   (fe),
    .i_RX_SbMessage        (msg),
    .i_msg_valid           (vld),
    .i_RX_data             (data),
    .i_clk_pattern_done    (pdone),
    .o_TX_SbMessage        (txMsg),
    .o_ValidOutDatat_Module(txValid),
    .o_clk_pattern_en      (patternEn),
    .o_MBINIT_REPAIRCLK_end(stageEnd),
    .o_REPAIRCLK_error     (stageError)
  );

  function automatic vec_t mk(logic r, logic c, logic b, logic f, logic v,
                              logic [3:0] m, logic [2:0] d, logic p, logic [7:0] e);
    vec_t t;
    t.rst = r; t.cal = c; t.busy = b; t.fe = f; t.vld = v;
    t.msg = m; t.data = d; t.pdone = p; t.expOut = e;
    return t;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst   = v.rst;
    cal   = v.cal;
    busy  = v.busy;
    fe    = v.fe;
    vld   = v.vld;
    msg   = v.msg;
    data  = v.data;
    pdone = v.pdone;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expOut);
    logic [7:0] act;
    act = {txMsg, txValid, patternEn, stageEnd, stageError};
    checks++;
    if (act !== expOut) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, expOut);
    end
  endtask

  task automatic stepCheck(input string name, input logic c, input logic b, input logic f,
                           input logic v, input logic [3:0] m, input logic [2:0] d,
                           input logic p, input logic [7:0] e);
    applyStimulus(mk(1'b0, c, b, f, v, m, d, p, e));
    checkOutput(name, e);
  endtask

  task automatic gotoPattern(input string tag);
    stepCheck({tag, "_sinit"}, 1, 0, 0, 0, 4'd0, 3'd0, 0, E_SINIT);
    stepCheck({tag, "_winit"}, 1, 0, 1, 0, 4'd0, 3'd0, 0, E_IDLE);
    stepCheck({tag, "_pat"},   1, 0, 0, 1, INIT_RESP, 3'd0, 0, E_PAT);
  endtask

  initial begin
    rst = 1'b1; cal = 1'b0; busy = 1'b0; fe = 1'b0;
    vld = 1'b0; msg = '0; data = '0; pdone = 1'b0;

    // Happy path, stray message, busy hold, then a failing result
    vecs.push_back(mk(1, 1, 0, 0, 0, 4'd0, 3'd0, 0, E_IDLE));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 3'd0, 0, E_IDLE));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 3'd0, 0, E_SINIT));
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'd0, 3'd0, 0, E_SINIT));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 3'd0, 0, E_SINIT));
    vecs.push_back(mk(0, 1, 0, 1, 0, 4'd0, 3'd0, 0, E_IDLE));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 3'd0, 0, E_IDLE));
    vecs.push_back(mk(0, 1, 0, 0, 1, DONE_RESP, 3'd0, 0, E_IDLE));
    vecs.push_back(mk(0, 1, 0, 0, 1, INIT_RESP, 3'd0, 0, E_PAT));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 3'd0, 0, E_PAT));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 3'd0, 1, E_SRES));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 3'd0, 0, E_SRES));
    vecs.push_back(mk(0, 1, 0, 1, 0, 4'd0, 3'd0, 0, E_IDLE));
    vecs.push_back(mk(0, 1, 0, 0, 1, DONE_RESP, 3'd7, 0, E_IDLE));
    vecs.push_back(mk(0, 1, 0, 0, 1, RESULT_RESP, 3'd7, 0, E_SDONE));
    vecs.push_back(mk(0, 1, 0, 1, 0, 4'd0, 3'd0, 0, E_IDLE));
    vecs.push_back(mk(0, 1, 0, 0, 1, DONE_RESP, 3'd0, 0, E_DONE));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 3'd0, 0, E_DONE));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 3'd0, 0, E_IDLE));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 3'd0, 0, E_SINIT));
    vecs.push_back(mk(0, 1, 0, 1, 0, 4'd0, 3'd0, 0, E_IDLE));
    vecs.push_back(mk(0, 1, 0, 0, 1, INIT_RESP, 3'd0, 0, E_PAT));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 3'd0, 1, E_SRES));
    vecs.push_back(mk(0, 1, 0, 1, 0, 4'd0, 3'd0, 0, E_IDLE));
    vecs.push_back(mk(0, 1, 0, 0, 1, RESULT_RESP, 3'd5, 0, E_ERR));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 3'd0, 0, E_ERR));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 3'd0, 0, E_IDLE));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].expOut);
    end

    // Timeout in WAIT_INIT: 16 cycles there, error appears with the 16th edge
    stepCheck("to_sinit", 1, 0, 0, 0, 4'd0, 3'd0, 0, E_SINIT);
    stepCheck("to_winit", 1, 0, 1, 0, 4'd0, 3'd0, 0, E_IDLE);
    for (int k = 1; k <= 15; k++) begin
      stepCheck($sformatf("to_wait%0d", k), 1, 0, 0, 0, 4'd0, 3'd0, 0, E_IDLE);
    end
    stepCheck("to_expire", 1, 0, 0, 0, 4'd0, 3'd0, 0, E_ERR);
    stepCheck("to_clear", 0, 0, 0, 0, 4'd0, 3'd0, 0, E_IDLE);

    // Race: DONE_resp on the cycle the WAIT_DONE timeout expires
    gotoPattern("race");
    stepCheck("race_sres",  1, 0, 0, 0, 4'd0, 3'd0, 1, E_SRES);
    stepCheck("race_wres",  1, 0, 1, 0, 4'd0, 3'd0, 0, E_IDLE);
    stepCheck("race_sdone", 1, 0, 0, 1, RESULT_RESP, 3'd7, 0, E_SDONE);
    stepCheck("race_wdone", 1, 0, 1, 0, 4'd0, 3'd0, 0, E_IDLE);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(mk(0, 1, 0, 0, 0, 4'd0, 3'd0, 0, E_IDLE));
    end
    checkOutput("race_wait15", E_IDLE);
    stepCheck("race_done", 1, 0, 0, 1, DONE_RESP, 3'd0, 0, E_DONE);
    stepCheck("race_hold", 1, 0, 0, 0, 4'd0, 3'd0, 0, E_DONE);
    stepCheck("race_clear", 0, 0, 0, 0, 4'd0, 3'd0, 0, E_IDLE);

    // Abort by dropping the enable during PATTERN, including a same-cycle pattern_done
    gotoPattern("abort");
    stepCheck("abort_drop", 0, 0, 0, 0, 4'd0, 3'd0, 1, E_IDLE);
    stepCheck("abort_restart", 1, 0, 0, 0, 4'd0, 3'd0, 0, E_SINIT);
    stepCheck("abort_winit", 1, 0, 1, 0, 4'd0, 3'd0, 0, E_IDLE);
    stepCheck("abort_pat", 1, 0, 0, 1, INIT_RESP, 3'd0, 0, E_PAT);

    // Reset during PATTERN drops pattern_en on the same edge
    applyStimulus(mk(1, 1, 0, 0, 0, 4'd0, 3'd0, 1, E_IDLE));
    checkOutput("rst_pattern", E_IDLE);
    stepCheck("rst_restart", 1, 0, 0, 0, 4'd0, 3'd0, 0, E_SINIT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
